block_ram_arbiter: RTL

//  Shares one simple-dual-port block RAM (1 read port, 1 write port, 1-cycle registered read)

---
 rtl/block_ram_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter that shares one simple-dual-port block RAM among N requesters.
// Define BRAM_ARB_FWD_EN to forward same-cycle write data to a colliding read (write-first).
module block_ram_arbiter #(
  parameter  int W = 32,
  parameter  int L = 375,
  parameter  int N = 2,
  localparam int A = $clog2(L)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_rd,
  input  logic [N*A-1:0]   req_rd_addr,
  output logic [N-1:0]     gnt_rd,
  output logic [N-1:0]     rd_valid,
  output logic [W-1:0]     rd_data,
  input  logic [N-1:0]     req_wr,
  input  logic [N*A-1:0]   req_wr_addr,
  input  logic [N*W-1:0]   req_wr_data,
  output logic [N-1:0]     gnt_wr,
  output logic [A-1:0]     ram_rd_addr,
  input  logic [W-1:0]     ram_rd_data,
  output logic [A-1:0]     ram_wr_addr,
  output logic             ram_wr_ena,
  output logic [W-1:0]     ram_wr_data
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Returns {found, index}; scanning offsets high-to-low lets the nearest requester win.
  function automatic logic [PW:0] rr_pick(input logic [N-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [A-1:0] rd_addr_a [N];
  logic [A-1:0] wr_addr_a [N];
  logic [W-1:0] wr_data_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign rd_addr_a[gi] = req_rd_addr[gi*A +: A];
    assign wr_addr_a[gi] = req_wr_addr[gi*A +: A];
    assign wr_data_a[gi] = req_wr_data[gi*W +: W];
  end

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [N-1:0]  rd_valid_q;
  logic          rd_oor_q;
  logic [PW:0]   rd_pick, wr_pick;
  logic          rd_found, wr_found;
  logic [PW-1:0] rd_idx, wr_idx;
  logic [A-1:0]  rd_addr_sel, wr_addr_sel;
  logic          rd_oor, wr_oor;

  assign rd_pick  = rr_pick(req_rd, rd_ptr_q);
  assign wr_pick  = rr_pick(req_wr, wr_ptr_q);
  assign rd_found = rd_pick[PW] & ~rst;
  assign wr_found = wr_pick[PW] & ~rst;
  assign rd_idx   = rd_pick[PW-1:0];
  assign wr_idx   = wr_pick[PW-1:0];

  assign rd_addr_sel = rd_addr_a[rd_idx];
  assign wr_addr_sel = wr_addr_a[wr_idx];
  assign rd_oor      = int'(rd_addr_sel) >= L;
  assign wr_oor      = int'(wr_addr_sel) >= L;

  assign gnt_rd = rd_found ? (N'(1) << rd_idx) : '0;
  assign gnt_wr = wr_found ? (N'(1) << wr_idx) : '0;

  assign ram_rd_addr = rd_found ? rd_addr_sel : '0;
  assign ram_wr_addr = wr_found ? wr_addr_sel : '0;
  assign ram_wr_data = wr_found ? wr_data_a[wr_idx] : '0;
  // Out-of-range writes are still granted for fairness but never reach the RAM.
  assign ram_wr_ena  = wr_found & ~wr_oor;

  assign rd_ptr_d = rd_found ? PW'((int'(rd_idx) + 1) % N) : rd_ptr_q;
  assign wr_ptr_d = wr_found ? PW'((int'(wr_idx) + 1) % N) : wr_ptr_q;

  assign rd_valid = rd_valid_q;

`ifdef BRAM_ARB_FWD_EN
  logic          fwd_q;
  logic [W-1:0]  fwd_data_q;
  logic          fwd_d;

  assign fwd_d   = rd_found & wr_found & ~wr_oor & (rd_addr_sel == wr_addr_sel);
  assign rd_data = rd_oor_q ? '0 : (fwd_q ? fwd_data_q : ram_rd_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= wr_data_a[wr_idx];
    end
  end
`else
  assign rd_data = rd_oor_q ? '0 : ram_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_valid_q <= '0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= gnt_rd;
      rd_oor_q   <= rd_found & rd_oor;
    end
  end

endmodule
